// File: rtl/uart_img_tx.sv
// Image transmitter: sends a 0x55/0xAA preamble separated by a fixed gap, then
// streams img_len bytes from memory. While idle, CPU writes pass through to the uart.
module uart_img_tx #(
  parameter int CLOCK_HZ   = 27_000_000,
  parameter int DATA_BITS  = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int GAP_CYCLES = CLOCK_HZ / 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_BITS-1:0]  tx_data,
  input  logic                  wr,
  output logic                  tx_ready,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] img_base,
  input  logic [ADDR_WIDTH-1:0] img_len,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_BITS-1:0]  mem_data,
  output logic [DATA_BITS-1:0]  uart_tx_data,
  output logic                  uart_wr,
  input  logic                  uart_tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int GAP_W = $clog2(GAP_CYCLES);
  // GAP is entered one cycle after the 0x55 write and PREAA issues 0xAA one
  // cycle after leaving GAP, so GAP lasts GAP_CYCLES-1 cycles.
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYCLES - 2);
  localparam logic [DATA_BITS-1:0] SYNC_A   = DATA_BITS'('h55);
  localparam logic [DATA_BITS-1:0] SYNC_B   = DATA_BITS'('hAA);

  typedef enum logic [2:0] {
    IDLE, PRE55, GAP, PREAA, FETCH, LOAD, SEND, FIN
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] rem_reg;
  logic [GAP_W-1:0]      gap_cnt_reg;
  logic [DATA_BITS-1:0]  byte_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = PRE55;
      PRE55: if (uart_tx_ready) state_next = GAP;
      GAP:   if (gap_cnt_reg == GAP_LAST) state_next = PREAA;
      PREAA: if (uart_tx_ready) state_next = (rem_reg != '0) ? FETCH : FIN;
      FETCH: state_next = LOAD;
      LOAD:  state_next = SEND;
      SEND:  if (uart_tx_ready) state_next = (rem_reg == ADDR_WIDTH'(1)) ? FIN : FETCH;
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_ready     = 1'b0;
    uart_wr      = 1'b0;
    uart_tx_data = byte_reg;
    mem_rd       = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state_reg)
      IDLE: begin
        busy         = 1'b0;
        tx_ready     = uart_tx_ready & ~start;
        uart_wr      = wr & uart_tx_ready & ~start;
        uart_tx_data = tx_data;
      end
      PRE55: begin
        uart_wr      = uart_tx_ready;
        uart_tx_data = SYNC_A;
      end
      PREAA: begin
        uart_wr      = uart_tx_ready;
        uart_tx_data = SYNC_B;
      end
      FETCH: mem_rd = 1'b1;
      SEND:  uart_wr = uart_tx_ready;
      FIN: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg    <= '0;
      rem_reg     <= '0;
      gap_cnt_reg <= '0;
      byte_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          addr_reg <= img_base;
          rem_reg  <= img_len;
        end
        PRE55: gap_cnt_reg <= '0;
        GAP:   gap_cnt_reg <= gap_cnt_reg + 1'b1;
        LOAD:  byte_reg <= mem_data;
        SEND: if (uart_tx_ready) begin
          addr_reg <= addr_reg + 1'b1;
          rem_reg  <= rem_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = addr_reg;

endmodule

// File: tb/tb_uart_img_tx.sv
// Bench for uart_img_tx: idle-mode vector table, then scoreboarded image sends
// with a uart model that drops ready for 10 cycles after each accepted byte.
module tb_uart_img_tx;
  localparam int GAP = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        wr = 1'b0;
  logic        tx_ready;
  logic        start = 1'b0;
  logic [15:0] img_base = '0;
  logic [15:0] img_len = '0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = '0;
  logic [7:0]  uart_tx_data;
  logic        uart_wr;
  logic        uart_tx_ready;
  logic        busy;
  logic        done;

  uart_img_tx #(
    .CLOCK_HZ(100_000), .DATA_BITS(8), .ADDR_WIDTH(16), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .wr(wr), .tx_ready(tx_ready),
    .start(start), .img_base(img_base), .img_len(img_len), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_data(mem_data), .uart_tx_data(uart_tx_data),
    .uart_wr(uart_wr), .uart_tx_ready(uart_tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ucnt = 0;
  int done_cnt = 0;
  logic force_en = 1'b1;
  logic force_val = 1'b1;
  logic mon_en = 1'b0;
  logic [7:0] mem [0:65535];
  logic [7:0] exp_q[$];
  int wr_cyc_q[$];
  logic [15:0] addr_q[$];

  assign uart_tx_ready = force_en ? force_val : (ucnt == 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_wr && uart_tx_ready) ucnt <= 10;
    else if (ucnt != 0)           ucnt <= ucnt - 1;
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_rd) addr_q.push_back(mem_addr);
    if (uart_wr && mon_en) begin
      logic [7:0] e;
      wr_cyc_q.push_back(cyc);
      n_cmp++;
      if (!uart_tx_ready) begin
        n_err++;
        $display("FAIL wr_without_ready: uart_wr=1 with uart_tx_ready=0 at cycle %0d", cyc);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_uart_wr: got byte %02h at cycle %0d, required no write", uart_tx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (uart_tx_data !== e) begin
          n_err++;
          $display("FAIL uart_byte: got %02h, required %02h", uart_tx_data, e);
        end else begin
          $display("uart byte %02h at cycle %0d", uart_tx_data, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One image transfer, optionally with a competing start and CPU writes mid-send.
  task automatic run_image(input logic [15:0] base, input int len,
                           input logic [7:0] seed, input bit contend);
    logic [7:0] b;
    exp_q.delete();
    wr_cyc_q.delete();
    addr_q.delete();
    done_cnt = 0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    for (int i = 0; i < len; i++) begin
      b = 8'(seed * (i + 1));
      mem[16'(base + 16'(i))] = b;
      exp_q.push_back(b);
    end
    $display("image base=%04h len=%0d contend=%0d", base, len, contend);
    tick;
    img_base = base;
    img_len = 16'(len);
    start = 1'b1;
    tick;
    start = 1'b0;
    if (contend) begin
      repeat (5) tick;
      check("busy_during_send", {31'b0, busy}, 1);
      check("tx_ready_during_send", {31'b0, tx_ready}, 0);
      img_base = 16'h2000;
      img_len = 16'd7;
      start = 1'b1;
      wr = 1'b1;
      tx_data = 8'h99;
      tick;
      start = 1'b0;
      repeat (2) tick;
      wr = 1'b0;
    end
    for (int i = 0; i < 5000 && done_cnt == 0; i++) tick;
    check("done_seen", {31'b0, done_cnt != 0}, 1);
    repeat (5) tick;
    check("done_once", 32'(done_cnt), 1);
    check("busy_after", {31'b0, busy}, 0);
    check("bytes_left", 32'(exp_q.size()), 0);
    check("wr_count", 32'(wr_cyc_q.size()), 32'(len + 2));
    if (wr_cyc_q.size() >= 2)
      check("gap_55_aa", 32'(wr_cyc_q[1] - wr_cyc_q[0]), GAP);
    check("addr_count", 32'(addr_q.size()), 32'(len));
    for (int i = 0; i < len && i < addr_q.size(); i++)
      check("mem_addr", {16'b0, addr_q[i]}, {16'b0, 16'(base + 16'(i))});
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       st;
    logic       rdy;
    logic       exp_wr;
    logic       exp_rdy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{wr: 1'b0, d: 8'h00, st: 1'b0, rdy: 1'b1, exp_wr: 1'b0, exp_rdy: 1'b1};
    vecs[1] = '{wr: 1'b1, d: 8'h41, st: 1'b0, rdy: 1'b1, exp_wr: 1'b1, exp_rdy: 1'b1};
    vecs[2] = '{wr: 1'b1, d: 8'h7E, st: 1'b0, rdy: 1'b0, exp_wr: 1'b0, exp_rdy: 1'b0};
    vecs[3] = '{wr: 1'b1, d: 8'h5A, st: 1'b1, rdy: 1'b1, exp_wr: 1'b0, exp_rdy: 1'b0};
    vecs[4] = '{wr: 1'b0, d: 8'h00, st: 1'b1, rdy: 1'b1, exp_wr: 1'b0, exp_rdy: 1'b0};
    vecs[5] = '{wr: 1'b1, d: 8'hC3, st: 1'b0, rdy: 1'b1, exp_wr: 1'b1, exp_rdy: 1'b1};

    // Reset state, with tx_ready tracking the uart ready input.
    rst_n = 1'b0;
    repeat (3) tick;
    force_val = 1'b1;
    #1;
    check("rst_tx_ready_hi", {31'b0, tx_ready}, 1);
    force_val = 1'b0;
    #1;
    check("rst_tx_ready_lo", {31'b0, tx_ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_uart_wr", {31'b0, uart_wr}, 0);
    check("rst_mem_rd", {31'b0, mem_rd}, 0);
    check("rst_mem_addr", {16'b0, mem_addr}, 0);
    tick;
    rst_n = 1'b1;
    tick;

    // Idle combinational behaviour; inputs withdrawn before the next edge.
    for (int i = 0; i < 6; i++) begin
      tick;
      wr = vecs[i].wr;
      tx_data = vecs[i].d;
      start = vecs[i].st;
      force_val = vecs[i].rdy;
      #2;
      $display("vec %0d wr=%0d d=%02h start=%0d rdy=%0d -> uart_wr=%0d tx_ready=%0d",
               i, wr, tx_data, start, force_val, uart_wr, tx_ready);
      check("vec_uart_wr", {31'b0, uart_wr}, {31'b0, vecs[i].exp_wr});
      check("vec_tx_ready", {31'b0, tx_ready}, {31'b0, vecs[i].exp_rdy});
      check("vec_busy", {31'b0, busy}, 0);
      if (vecs[i].exp_wr)
        check("vec_uart_data", {24'b0, uart_tx_data}, {24'b0, vecs[i].d});
      wr = 1'b0;
      start = 1'b0;
    end

    force_en = 1'b0;
    mon_en = 1'b1;
    repeat (3) tick;

    // Passthrough through the scoreboard.
    exp_q.push_back(8'h41);
    for (int i = 0; i < 100 && !tx_ready; i++) tick;
    wr = 1'b1;
    tx_data = 8'h41;
    tick;
    wr = 1'b0;
    repeat (20) tick;
    check("passthru_consumed", 32'(exp_q.size()), 0);
    check("passthru_no_busy", {31'b0, busy}, 0);

    run_image(16'h0100, 3, 8'h11, 1'b0);
    run_image(16'h0200, 0, 8'h00, 1'b0);
    run_image(16'hFFFF, 2, 8'h05, 1'b0);
    run_image(16'h0400, 3, 8'h21, 1'b1);

    // Reset mid-stream after 0xAA and the first data byte.
    exp_q.delete();
    wr_cyc_q.delete();
    addr_q.delete();
    done_cnt = 0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 5; i++) begin
      mem[16'h0300 + 16'(i)] = 8'(8'h07 * (i + 1));
      exp_q.push_back(8'(8'h07 * (i + 1)));
    end
    $display("image base=0300 len=5 with reset mid-stream");
    tick;
    img_base = 16'h0300;
    img_len = 16'd5;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3000 && wr_cyc_q.size() < 3; i++) tick;
    check("reached_stream", 32'(wr_cyc_q.size()), 3);
    tick;
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check("midrst_uart_wr", {31'b0, uart_wr}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (50) tick;
    check("midrst_no_more_wr", 32'(wr_cyc_q.size()), 3);
    check("midrst_no_done", 32'(done_cnt), 0);
    check("midrst_idle", {31'b0, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
